// File: rtl/ux607_qspi_icb_arb.sv
// ---------------------------------------------------------------------------
// ux607_qspi_icb_arb
// Two-requester ICB arbiter that shares one QSPI controller port between
// requester 0 (core/system) and requester 1 (boot/XIP or DMA). Only one
// transaction is outstanding at a time. Each response is routed back to the
// requester that issued the command. Grants are round-robin: after a
// transaction completes, its requester gets the lowest priority.
//
// Ports
//   clock, reset          : clock, asynchronous active-high reset
//   i0_icb_cmd_* / rsp_*  : requester 0 ICB command/response channels
//   i1_icb_cmd_* / rsp_*  : requester 1 ICB command/response channels
//   o_icb_cmd_* / rsp_*   : downstream ICB towards the QSPI wrapper
//   busy                  : high whenever the arbiter is not idle
//   grant_id              : current (or last) granted requester
//
// The data paths are combinational muxes. Only the state, the grant and
// the round-robin pointer are stored in registers.
// ---------------------------------------------------------------------------
module ux607_qspi_icb_arb #(
   parameter int unsigned AW = 32,
   parameter int unsigned DW = 32
) (
   input  logic          clock,
   input  logic          reset,

   input  logic          i0_icb_cmd_valid,
   output logic          i0_icb_cmd_ready,
   input  logic [AW-1:0] i0_icb_cmd_addr,
   input  logic          i0_icb_cmd_read,
   input  logic [DW-1:0] i0_icb_cmd_wdata,
   output logic          i0_icb_rsp_valid,
   input  logic          i0_icb_rsp_ready,
   output logic [DW-1:0] i0_icb_rsp_rdata,

   input  logic          i1_icb_cmd_valid,
   output logic          i1_icb_cmd_ready,
   input  logic [AW-1:0] i1_icb_cmd_addr,
   input  logic          i1_icb_cmd_read,
   input  logic [DW-1:0] i1_icb_cmd_wdata,
   output logic          i1_icb_rsp_valid,
   input  logic          i1_icb_rsp_ready,
   output logic [DW-1:0] i1_icb_rsp_rdata,

   output logic          o_icb_cmd_valid,
   input  logic          o_icb_cmd_ready,
   output logic [AW-1:0] o_icb_cmd_addr,
   output logic          o_icb_cmd_read,
   output logic [DW-1:0] o_icb_cmd_wdata,
   input  logic          o_icb_rsp_valid,
   output logic          o_icb_rsp_ready,
   input  logic [DW-1:0] o_icb_rsp_rdata,

   output logic          busy,
   output logic          grant_id
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_CMD  = 2'd1,
      ST_RSP  = 2'd2
   } state_t;

   state_t r_state;
   logic   r_grant_id;
   logic   r_rr_ptr;

   logic   w_any_req;
   logic   w_pick;
   logic   w_in_cmd;
   logic   w_in_rsp;
   logic   w_cmd_hs;
   logic   w_rsp_hs;

   // When both requesters are valid, the round-robin pointer picks the winner.
   // Otherwise the only valid requester wins.
   assign w_any_req = i0_icb_cmd_valid | i1_icb_cmd_valid;
   assign w_pick    = (i0_icb_cmd_valid & i1_icb_cmd_valid) ? r_rr_ptr : i1_icb_cmd_valid;

   assign w_in_cmd  = (r_state == ST_CMD);
   assign w_in_rsp  = (r_state == ST_RSP);
   assign w_cmd_hs  = o_icb_cmd_valid & o_icb_cmd_ready;
   assign w_rsp_hs  = o_icb_rsp_valid & o_icb_rsp_ready;

   // Arbitration FSM: IDLE registers the grant, CMD waits for the downstream
   // command handshake, RSP waits for the routed response handshake.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_state    <= ST_IDLE;
         r_grant_id <= 1'b0;
         r_rr_ptr   <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (w_any_req) begin
                  r_grant_id <= w_pick;
                  r_state    <= ST_CMD;
               end
            end
            ST_CMD: begin
               if (w_cmd_hs) r_state <= ST_RSP;
            end
            ST_RSP: begin
               if (w_rsp_hs) begin
                  r_state  <= ST_IDLE;
                  r_rr_ptr <= ~r_grant_id;
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   // Command path: the granted requester drives downstream only in CMD.
   // Outside CMD the outputs are zero, so during reset they are also zero.
   assign o_icb_cmd_valid  = w_in_cmd & (r_grant_id ? i1_icb_cmd_valid : i0_icb_cmd_valid);
   assign o_icb_cmd_addr   = w_in_cmd ? (r_grant_id ? i1_icb_cmd_addr  : i0_icb_cmd_addr)  : '0;
   assign o_icb_cmd_read   = w_in_cmd & (r_grant_id ? i1_icb_cmd_read  : i0_icb_cmd_read);
   assign o_icb_cmd_wdata  = w_in_cmd ? (r_grant_id ? i1_icb_cmd_wdata : i0_icb_cmd_wdata) : '0;
   assign i0_icb_cmd_ready = w_in_cmd & ~r_grant_id & o_icb_cmd_ready;
   assign i1_icb_cmd_ready = w_in_cmd &  r_grant_id & o_icb_cmd_ready;

   // Response path: the valid/ready pair is steered to the granted requester.
   // Read data goes to both requesters; it only counts when valid is high.
   assign i0_icb_rsp_valid = w_in_rsp & ~r_grant_id & o_icb_rsp_valid;
   assign i1_icb_rsp_valid = w_in_rsp &  r_grant_id & o_icb_rsp_valid;
   assign o_icb_rsp_ready  = w_in_rsp & (r_grant_id ? i1_icb_rsp_ready : i0_icb_rsp_ready);
   assign i0_icb_rsp_rdata = o_icb_rsp_rdata;
   assign i1_icb_rsp_rdata = o_icb_rsp_rdata;

   assign busy     = (r_state != ST_IDLE);
   assign grant_id = r_grant_id;

endmodule

// File: tb/tb_ux607_qspi_icb_arb.sv
// ---------------------------------------------------------------------------
// tb_ux607_qspi_icb_arb
// Self-checking bench for the two-requester QSPI ICB arbiter. Directed
// scenarios cover these cases:
//   - the arbitration latency
//   - a stall of the downstream command ready
//   - backpressure on the response
//   - a reset during a response
// After the directed scenarios, traffic runs at transaction level. Each
// requester tags its addresses with its own id. A downstream slave model
// returns data that is a fixed function of the address. Routing and
// data integrity are checked against this model, and grant alternation is
// checked under continuous load.
// ---------------------------------------------------------------------------
module tb_ux607_qspi_icb_arb;

   localparam int unsigned AW = 32;
   localparam int unsigned DW = 32;

   logic          clock;
   logic          reset;
   logic          i0_icb_cmd_valid, i0_icb_cmd_ready, i0_icb_cmd_read;
   logic [AW-1:0] i0_icb_cmd_addr;
   logic [DW-1:0] i0_icb_cmd_wdata;
   logic          i0_icb_rsp_valid, i0_icb_rsp_ready;
   logic [DW-1:0] i0_icb_rsp_rdata;
   logic          i1_icb_cmd_valid, i1_icb_cmd_ready, i1_icb_cmd_read;
   logic [AW-1:0] i1_icb_cmd_addr;
   logic [DW-1:0] i1_icb_cmd_wdata;
   logic          i1_icb_rsp_valid, i1_icb_rsp_ready;
   logic [DW-1:0] i1_icb_rsp_rdata;
   logic          o_icb_cmd_valid, o_icb_cmd_ready, o_icb_cmd_read;
   logic [AW-1:0] o_icb_cmd_addr;
   logic [DW-1:0] o_icb_cmd_wdata;
   logic          o_icb_rsp_valid, o_icb_rsp_ready;
   logic [DW-1:0] o_icb_rsp_rdata;
   logic          busy, grant_id;

   ux607_qspi_icb_arb #(.AW(AW), .DW(DW)) u_dut (
      .clock            (clock),
      .reset            (reset),
      .i0_icb_cmd_valid (i0_icb_cmd_valid),
      .i0_icb_cmd_ready (i0_icb_cmd_ready),
      .i0_icb_cmd_addr  (i0_icb_cmd_addr),
      .i0_icb_cmd_read  (i0_icb_cmd_read),
      .i0_icb_cmd_wdata (i0_icb_cmd_wdata),
      .i0_icb_rsp_valid (i0_icb_rsp_valid),
      .i0_icb_rsp_ready (i0_icb_rsp_ready),
      .i0_icb_rsp_rdata (i0_icb_rsp_rdata),
      .i1_icb_cmd_valid (i1_icb_cmd_valid),
      .i1_icb_cmd_ready (i1_icb_cmd_ready),
      .i1_icb_cmd_addr  (i1_icb_cmd_addr),
      .i1_icb_cmd_read  (i1_icb_cmd_read),
      .i1_icb_cmd_wdata (i1_icb_cmd_wdata),
      .i1_icb_rsp_valid (i1_icb_rsp_valid),
      .i1_icb_rsp_ready (i1_icb_rsp_ready),
      .i1_icb_rsp_rdata (i1_icb_rsp_rdata),
      .o_icb_cmd_valid  (o_icb_cmd_valid),
      .o_icb_cmd_ready  (o_icb_cmd_ready),
      .o_icb_cmd_addr   (o_icb_cmd_addr),
      .o_icb_cmd_read   (o_icb_cmd_read),
      .o_icb_cmd_wdata  (o_icb_cmd_wdata),
      .o_icb_rsp_valid  (o_icb_rsp_valid),
      .o_icb_rsp_ready  (o_icb_rsp_ready),
      .o_icb_rsp_rdata  (o_icb_rsp_rdata),
      .busy             (busy),
      .grant_id         (grant_id)
   );

   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   int total = 0;
   int bad   = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%08h want 0x%08h", tag, obs, exp);
      end
   endtask

   // Slave response data is a bijective function of the address.
   function automatic logic [31:0] rsp_of(input logic [31:0] a);
      return {a[15:0], a[31:16]} ^ 32'h5A5A_A5A5;
   endfunction

   task automatic tick();
      @(posedge clock);
      @(negedge clock);
   endtask

   task automatic clear_inputs();
      i0_icb_cmd_valid = 1'b0; i0_icb_cmd_addr = '0; i0_icb_cmd_read = 1'b0;
      i0_icb_cmd_wdata = '0;   i0_icb_rsp_ready = 1'b0;
      i1_icb_cmd_valid = 1'b0; i1_icb_cmd_addr = '0; i1_icb_cmd_read = 1'b0;
      i1_icb_cmd_wdata = '0;   i1_icb_rsp_ready = 1'b0;
      o_icb_cmd_ready  = 1'b0; o_icb_rsp_valid = 1'b0; o_icb_rsp_rdata = '0;
   endtask

   task automatic apply_reset();
      reset = 1'b1;
      clear_inputs();
      repeat (2) @(negedge clock);
      reset = 1'b0;
   endtask

   task automatic chk_quiet(input string pfx);
      chk({pfx, "_busy"},      32'(busy),             32'd0);
      chk({pfx, "_ocmd_vld"},  32'(o_icb_cmd_valid),  32'd0);
      chk({pfx, "_orsp_rdy"},  32'(o_icb_rsp_ready),  32'd0);
      chk({pfx, "_i0_cmdrdy"}, 32'(i0_icb_cmd_ready), 32'd0);
      chk({pfx, "_i1_cmdrdy"}, 32'(i1_icb_cmd_ready), 32'd0);
      chk({pfx, "_i0_rspvld"}, 32'(i0_icb_rsp_valid), 32'd0);
      chk({pfx, "_i1_rspvld"}, 32'(i1_icb_rsp_valid), 32'd0);
      chk({pfx, "_addr"},      o_icb_cmd_addr,        32'd0);
      chk({pfx, "_wdata"},     o_icb_cmd_wdata,       32'd0);
      chk({pfx, "_read"},      32'(o_icb_cmd_read),   32'd0);
   endtask

   // Transaction-level traffic with a requester model and a slave model.
   // cont=1 keeps both requesters valid and the slave always ready, so
   // grants are expected to alternate strictly, starting at requester 0.
   task automatic run_traffic(input int n_each, input bit cont, input int max_cyc);
      bit          pres[2];
      bit          outst[2];
      logic [31:0] caddr[2], cwd[2], exp_rd[2];
      logic        cread[2];
      int          left[2], done[2], grants[2];
      int          prev_w, w, cyc, s_dly;
      bit          s_pend, rv, rr, hs_any;
      logic [31:0] s_rd, tmp;
      for (int r = 0; r < 2; r++) begin
         pres[r] = 1'b0; outst[r] = 1'b0; left[r] = n_each; done[r] = 0; grants[r] = 0;
         caddr[r] = '0; cwd[r] = '0; exp_rd[r] = '0; cread[r] = 1'b0;
      end
      prev_w = -1; cyc = 0; s_pend = 1'b0; s_dly = 0; s_rd = '0;
      while ((done[0] < n_each || done[1] < n_each) && cyc < max_cyc) begin
         for (int r = 0; r < 2; r++) begin
            if (!pres[r] && left[r] > 0 && (cont || $urandom_range(0, 2) == 0)) begin
               pres[r]  = 1'b1;
               left[r]--;
               tmp      = $urandom();
               caddr[r] = {tmp[31:1], 1'(r)};
               cread[r] = 1'($urandom_range(0, 1));
               cwd[r]   = $urandom();
            end
         end
         i0_icb_cmd_valid = pres[0]; i0_icb_cmd_addr = caddr[0];
         i0_icb_cmd_read  = cread[0]; i0_icb_cmd_wdata = cwd[0];
         i1_icb_cmd_valid = pres[1]; i1_icb_cmd_addr = caddr[1];
         i1_icb_cmd_read  = cread[1]; i1_icb_cmd_wdata = cwd[1];
         i0_icb_rsp_ready = cont ? 1'b1 : 1'($urandom_range(0, 1));
         i1_icb_rsp_ready = cont ? 1'b1 : 1'($urandom_range(0, 1));
         o_icb_cmd_ready  = cont ? 1'b1 : ($urandom_range(0, 3) != 0);
         o_icb_rsp_valid  = s_pend && (s_dly == 0);
         o_icb_rsp_rdata  = s_pend ? s_rd : 32'($urandom());
         #1;
         // Responses as seen by each requester.
         hs_any = 1'b0;
         for (int r = 0; r < 2; r++) begin
            rv = (r == 0) ? i0_icb_rsp_valid : i1_icb_rsp_valid;
            rr = (r == 0) ? i0_icb_rsp_ready : i1_icb_rsp_ready;
            if (rv) chk($sformatf("rsp_owner%0d", r), 32'(outst[r]), 32'd1);
            if (rv && rr) begin
               chk($sformatf("rsp_data%0d", r),
                   (r == 0) ? i0_icb_rsp_rdata : i1_icb_rsp_rdata, exp_rd[r]);
               outst[r] = 1'b0;
               done[r]++;
               hs_any = 1'b1;
            end
         end
         if (o_icb_rsp_valid && o_icb_rsp_ready) begin
            chk("rsp_hs_routed", 32'(hs_any), 32'd1);
            s_pend = 1'b0;
         end else if (s_pend && s_dly > 0) begin
            s_dly--;
         end
         // Commands accepted by the slave.
         if (o_icb_cmd_valid && o_icb_cmd_ready) begin
            w = i1_icb_cmd_ready ? 1 : 0;
            chk("cmd_rdy_cnt", 32'(i0_icb_cmd_ready) + 32'(i1_icb_cmd_ready), 32'd1);
            chk("cmd_from_valid", 32'(pres[w]), 32'd1);
            chk("cmd_addr",  o_icb_cmd_addr,         caddr[w]);
            chk("cmd_read",  32'(o_icb_cmd_read),    32'(cread[w]));
            chk("cmd_wdata", o_icb_cmd_wdata,        cwd[w]);
            chk("cmd_gid",   32'(grant_id),          32'(w));
            chk("one_outstanding", 32'(s_pend),      32'd0);
            if (cont) begin
               if (prev_w < 0) chk("first_grant", 32'(w), 32'd0);
               else            chk("alternate",   32'(w), 32'(1 - prev_w));
            end
            prev_w    = w;
            grants[w]++;
            pres[w]   = 1'b0;
            outst[w]  = 1'b1;
            exp_rd[w] = rsp_of(caddr[w]);
            s_pend    = 1'b1;
            s_rd      = rsp_of(o_icb_cmd_addr);
            s_dly     = cont ? 0 : $urandom_range(0, 3);
         end
         @(negedge clock);
         cyc++;
      end
      chk("done0", 32'(done[0]), 32'(n_each));
      chk("done1", 32'(done[1]), 32'(n_each));
      chk("grants0", 32'(grants[0]), 32'(n_each));
      chk("grants1", 32'(grants[1]), 32'(n_each));
   endtask

   initial begin
      reset = 1'b1;
      clear_inputs();
      repeat (2) @(negedge clock);
      #1;
      chk_quiet("rst");
      chk("rst_gid", 32'(grant_id), 32'd0);
      reset = 1'b0;

      // Single read from requester 0: one cycle of arbitration, then CMD, then RSP.
      i0_icb_cmd_valid = 1'b1; i0_icb_cmd_addr = 32'h0000_0010; i0_icb_cmd_read = 1'b1;
      o_icb_cmd_ready  = 1'b1;
      #1;
      chk("t1_latency_vld", 32'(o_icb_cmd_valid), 32'd0);
      chk("t1_latency_rdy", 32'(i0_icb_cmd_ready), 32'd0);
      tick(); #1;
      chk("t1_cmd_vld",  32'(o_icb_cmd_valid),  32'd1);
      chk("t1_cmd_addr", o_icb_cmd_addr,        32'h0000_0010);
      chk("t1_cmd_read", 32'(o_icb_cmd_read),   32'd1);
      chk("t1_gid",      32'(grant_id),         32'd0);
      chk("t1_i0_rdy",   32'(i0_icb_cmd_ready), 32'd1);
      chk("t1_i1_rdy",   32'(i1_icb_cmd_ready), 32'd0);
      chk("t1_busy",     32'(busy),             32'd1);
      tick();
      i0_icb_cmd_valid = 1'b0;
      o_icb_rsp_valid  = 1'b1; o_icb_rsp_rdata = 32'hA5A5_5A5A; i0_icb_rsp_ready = 1'b1;
      #1;
      chk("t1_i0_rspvld", 32'(i0_icb_rsp_valid), 32'd1);
      chk("t1_i0_rdata",  i0_icb_rsp_rdata,      32'hA5A5_5A5A);
      chk("t1_i1_rspvld", 32'(i1_icb_rsp_valid), 32'd0);
      chk("t1_orsp_rdy",  32'(o_icb_rsp_ready),  32'd1);
      tick();
      o_icb_rsp_valid = 1'b0;
      #1;
      chk("t1_idle_busy", 32'(busy), 32'd0);

      // Both requesters valid: i0 first, with a 5-cycle downstream command stall.
      apply_reset();
      i0_icb_cmd_valid = 1'b1; i0_icb_cmd_addr = 32'h0000_0020; i0_icb_cmd_read = 1'b1;
      i1_icb_cmd_valid = 1'b1; i1_icb_cmd_addr = 32'h0000_0030; i1_icb_cmd_read = 1'b0;
      i1_icb_cmd_wdata = 32'h1234_5678;
      tick();
      for (int k = 0; k < 5; k++) begin
         #1;
         chk("t2_stall_vld",  32'(o_icb_cmd_valid),  32'd1);
         chk("t2_stall_addr", o_icb_cmd_addr,        32'h0000_0020);
         chk("t2_stall_rdy0", 32'(i0_icb_cmd_ready), 32'd0);
         chk("t2_stall_rdy1", 32'(i1_icb_cmd_ready), 32'd0);
         chk("t2_stall_busy", 32'(busy),             32'd1);
         tick();
      end
      o_icb_cmd_ready = 1'b1;
      #1;
      chk("t2_i0_rdy",   32'(i0_icb_cmd_ready), 32'd1);
      chk("t2_i0_wdata", o_icb_cmd_wdata,       32'd0);
      tick();
      i0_icb_cmd_addr = 32'h0000_0024;
      o_icb_rsp_valid = 1'b1; o_icb_rsp_rdata = 32'h0BAD_0020; i0_icb_rsp_ready = 1'b1;
      #1;
      chk("t2_rsp_nocmd", 32'(o_icb_cmd_valid), 32'd0);
      chk("t2_rsp_wdata", o_icb_cmd_wdata,      32'd0);
      chk("t2_rsp_i0vld", 32'(i0_icb_rsp_valid), 32'd1);
      tick();
      o_icb_rsp_valid = 1'b0;
      #1;
      chk("t2_idle_wdata", o_icb_cmd_wdata, 32'd0);
      tick(); #1;
      chk("t2_gid1",    32'(grant_id),         32'd1);
      chk("t2_i1_wd",   o_icb_cmd_wdata,       32'h1234_5678);
      chk("t2_i1_rd",   32'(o_icb_cmd_read),   32'd0);
      chk("t2_i1_addr", o_icb_cmd_addr,        32'h0000_0030);
      chk("t2_i1_rdy",  32'(i1_icb_cmd_ready), 32'd1);
      chk("t2_i0_nrdy", 32'(i0_icb_cmd_ready), 32'd0);
      tick();
      i1_icb_cmd_valid = 1'b0;
      o_icb_rsp_valid  = 1'b1; o_icb_rsp_rdata = 32'hCAFE_0001; i1_icb_rsp_ready = 1'b0;
      // Requester 1 holds off its response for 3 cycles.
      for (int k = 0; k < 3; k++) begin
         #1;
         chk("t3_bp_orsprdy", 32'(o_icb_rsp_ready),  32'd0);
         chk("t3_bp_i1vld",   32'(i1_icb_rsp_valid), 32'd1);
         chk("t3_bp_i1data",  i1_icb_rsp_rdata,      32'hCAFE_0001);
         chk("t3_bp_i0vld",   32'(i0_icb_rsp_valid), 32'd0);
         chk("t3_bp_busy",    32'(busy),             32'd1);
         tick();
      end
      i1_icb_rsp_ready = 1'b1;
      #1;
      chk("t3_orsprdy", 32'(o_icb_rsp_ready), 32'd1);
      chk("t3_still_busy", 32'(busy), 32'd1);
      tick();
      o_icb_rsp_valid = 1'b0; i1_icb_rsp_ready = 1'b0;
      #1;
      chk("t3_idle", 32'(busy), 32'd0);
      tick(); #1;
      chk("t2_third_gid",  32'(grant_id),  32'd0);
      chk("t2_third_addr", o_icb_cmd_addr, 32'h0000_0024);
      tick();
      i0_icb_cmd_valid = 1'b0;
      o_icb_rsp_valid  = 1'b1; o_icb_rsp_rdata = 32'h0BAD_0024;
      tick();
      o_icb_rsp_valid = 1'b0; i0_icb_rsp_ready = 1'b0;

      // Requester 0 was served last. Requester 1 is granted next, and reset
      // hits while its response is pending.
      i1_icb_cmd_valid = 1'b1; i1_icb_cmd_addr = 32'h0000_0050;
      tick(); tick();
      i1_icb_cmd_valid = 1'b0;
      o_icb_rsp_valid  = 1'b1; o_icb_rsp_rdata = 32'h0BAD_0050; i1_icb_rsp_ready = 1'b1;
      #1;
      chk("t4_pre_i1vld", 32'(i1_icb_rsp_valid), 32'd1);
      chk("t4_pre_busy",  32'(busy),             32'd1);
      reset = 1'b1;
      #1;
      chk("t4_rst_busy",   32'(busy),             32'd0);
      chk("t4_rst_orsp",   32'(o_icb_rsp_ready),  32'd0);
      chk("t4_rst_i1vld",  32'(i1_icb_rsp_valid), 32'd0);
      chk("t4_rst_i0vld",  32'(i0_icb_rsp_valid), 32'd0);
      clear_inputs();
      @(negedge clock);
      reset = 1'b0;
      i0_icb_cmd_valid = 1'b1; i0_icb_cmd_addr = 32'h0000_0040;
      i1_icb_cmd_valid = 1'b1; i1_icb_cmd_addr = 32'h0000_0050;
      tick(); #1;
      chk("t4_post_gid",  32'(grant_id),  32'd0);
      chk("t4_post_addr", o_icb_cmd_addr, 32'h0000_0040);

      // 100 transactions under continuous load from both requesters.
      apply_reset();
      run_traffic(50, 1'b1, 2000);

      // Random valid, ready and latency on every channel.
      apply_reset();
      run_traffic(40, 1'b0, 8000);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/ux607_qspi_icb_arb.md
Name: ux607_qspi_icb_arb

Overview:
- Two-requester ICB arbiter in front of the QSPI 4-CS peripheral wrapper.
- Shares the single serial QSPI controller between requester 0 (core/system ICB) and requester 1 (boot/XIP fetch or DMA ICB).
- Allows exactly one outstanding transaction at a time.
- Routes each response back to the requester that issued the command, with round-robin fairness.

Parameters:
- AW, 32, address width (matches UX607_PA_SIZE); addresses pass through unmodified.
- DW, 32, data width for wdata/rdata.

Ports:
- clock  in  1  sole clock
- reset  in  1  asynchronous, active-high reset
- i0_icb_cmd_valid  in  1  requester 0 command valid
- i0_icb_cmd_ready  out  1  requester 0 command accepted
- i0_icb_cmd_addr  in  AW  requester 0 address
- i0_icb_cmd_read  in  1  requester 0 read=1 / write=0
- i0_icb_cmd_wdata  in  DW  requester 0 write data
- i0_icb_rsp_valid  out  1  requester 0 response valid
- i0_icb_rsp_ready  in  1  requester 0 response ready
- i0_icb_rsp_rdata  out  DW  requester 0 read data
- i1_icb_* (same 8 signals as i0)  requester 1
- o_icb_cmd_valid  out  1  to QSPI wrapper
- o_icb_cmd_ready  in  1  from QSPI wrapper
- o_icb_cmd_addr  out  AW  to QSPI wrapper
- o_icb_cmd_read  out  1  to QSPI wrapper
- o_icb_cmd_wdata  out  DW  to QSPI wrapper
- o_icb_rsp_valid  in  1  from QSPI wrapper
- o_icb_rsp_ready  out  1  to QSPI wrapper
- o_icb_rsp_rdata  in  DW  from QSPI wrapper
- busy  out  1  high when state is not IDLE
- grant_id  out  1  current or last granted requester

Behaviour:
- Clock and reset: single clock `clock`; reset `reset` is asynchronous and active-high.
- State register values: IDLE, CMD, RSP. Reset sets state=IDLE, grant_id=0, rr_ptr=0 (requester 0 preferred).
- Output values under reset:
  - all *_cmd_ready, *_rsp_valid, o_icb_cmd_valid, o_icb_rsp_ready = 0;
  - busy = 0;
  - o_icb_cmd_addr, o_icb_cmd_wdata, o_icb_cmd_read = 0.
- IDLE:
  - If exactly one requester has cmd_valid, it is granted.
  - If both, the requester equal to rr_ptr is granted.
  - Grant is registered into grant_id; state -> CMD next cycle.
  - No *_cmd_ready is asserted in IDLE, so arbitration latency is 1 cycle.
- CMD:
  - o_icb_cmd_valid = granted requester's cmd_valid; addr/read/wdata muxed combinationally from the granted requester.
  - Granted i*_icb_cmd_ready = o_icb_cmd_ready; the other requester's ready = 0.
  - On the o_icb_cmd handshake, state -> RSP.
  - If the granted requester drops valid (ICB violation), remain in CMD with o_icb_cmd_valid = 0; no grant switch.
- RSP:
  - Granted i*_icb_rsp_valid = o_icb_rsp_valid; rdata routed to both requesters (data only meaningful with valid); o_icb_rsp_ready = granted requester's rsp_ready.
  - The non-granted requester's rsp_valid = 0.
  - On the rsp handshake: state -> IDLE; rr_ptr = ~grant_id (last winner gets lowest priority).
- Response arrival: a response arriving before the cmd handshake cannot occur (the wrapper is in-order). o_icb_rsp_ready = 0 outside RSP.
- Back-to-back:
  - Minimum per-transaction overhead is 1 IDLE cycle after rsp handshake.
  - A requester may hold valid through IDLE; its transaction completes in CMD/RSP with no loss.
- Fairness: with both requesters continuously valid, grants strictly alternate 0,1,0,1...
- Reset mid-operation: immediate return to IDLE with outputs at reset values. The in-flight downstream transaction is abandoned; downstream is reset in the same domain.
- No buffering of data: all data paths are combinational muxes; only state, grant_id and rr_ptr are sequential.

Test Plan:
- Reset, then i0 read addr 0x000010 alone → grant_id=0; o_icb_cmd_valid rises 1 cycle after i0 valid; o_icb_cmd_read=1; downstream rdata 0xA5A5_5A5A returned on i0_icb_rsp_rdata with i0_icb_rsp_valid; i1 sees no valid.
- i0 and i1 both valid from reset → i0 served first (rr_ptr=0), then i1, then i0; i1 write wdata 0x1234_5678 appears on o_icb_cmd_wdata only during its CMD state.
- o_icb_cmd_ready held low 5 cycles in CMD → i*_cmd_ready low; o_icb_cmd_valid held stable with unchanged addr; state stays CMD.
- i1_icb_rsp_ready low 3 cycles while o_icb_rsp_valid=1 → o_icb_rsp_ready low, rdata held; IDLE entered only the cycle after ready rises.
- Assert reset during RSP → busy, o_icb_rsp_ready, i*_rsp_valid = 0 immediately (asynchronously); after release, the next grant goes to i0 when both requesters request.
- Continuous traffic from both for 100 transactions → exactly 50 grants each, no response misrouted (tag data with requester id).
